dmi_responder: RTL and testbench

// - Debug-domain DMI target. Sits at the far end of the DMI CDC, after the last clk-domain request stage.
// - Accepts one dm::dmi_req_t at a time and range-checks the address.
// - Performs one access on a simple register bus with wait states, then returns a dm::dmi_resp_t.
// - Non-pipelined: one outstanding request. A timeout guards against a hung register target.

---
 rtl/dmi_responder.sv | 182 ++++++++++++++++++
 tb/tb_dmi_responder.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmi_responder.sv
// dmi_responder: debug-domain DMI target that performs one register-bus access per request.
// Define DMI_RESP_STICKY_ERR_EN to latch FAILED responses and reject accesses until dmi_clear_i.
module dmi_responder #(
    parameter logic [6:0]  MAX_ADDR       = 7'h40,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        dmi_clear_i,
    input  logic [40:0] dmi_req_i,
    input  logic        dmi_req_valid_i,
    output logic        dmi_req_ready_o,
    output logic [33:0] dmi_resp_o,
    output logic        dmi_resp_valid_o,
    input  logic        dmi_resp_ready_i,
    output logic        reg_req_o,
    output logic        reg_we_o,
    output logic [6:0]  reg_addr_o,
    output logic [31:0] reg_wdata_o,
    input  logic        reg_gnt_i,
    input  logic        reg_rvalid_i,
    input  logic [31:0] reg_rdata_i
);

    typedef enum logic [1:0] {IDLE, ACCESS, RDATA, RESP} state_e;
    typedef enum logic [1:0] {OP_NOP, OP_READ, OP_WRITE, OP_RSVD} op_e;
    typedef enum logic [1:0] {RSP_SUCCESS = 2'd0, RSP_FAILED = 2'd2} resp_e;

    localparam logic [7:0] LAST_CYCLE = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q;
    logic [6:0]  addr_q;
    logic        we_q;
    logic [31:0] wdata_q;
    logic [31:0] resp_data_q;
    resp_e       resp_code_q;

    logic        load_resp;
    logic        resp_fail;
    logic        take_rdata;
    logic        accept;
    logic        reject;
    logic        timeout;
    logic [6:0]  req_addr;
    op_e         req_op;
    logic [31:0] req_data;

`ifdef DMI_RESP_STICKY_ERR_EN
    logic sticky_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sticky_err <= 1'b0;
        end else if (dmi_clear_i) begin
            sticky_err <= 1'b0;
        end else if (load_resp && resp_fail) begin
            sticky_err <= 1'b1;
        end
    end
`else
    logic sticky_err;
    assign sticky_err = 1'b0;
`endif

    assign req_addr = dmi_req_i[40:34];
    assign req_op   = op_e'(dmi_req_i[33:32]);
    assign req_data = dmi_req_i[31:0];
    assign accept   = dmi_req_valid_i && dmi_req_ready_o;
    assign reject   = (req_addr > MAX_ADDR) || (req_op == OP_RSVD) || sticky_err;
    assign timeout  = (cnt_q == LAST_CYCLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A grant or rvalid arriving in the timeout cycle takes precedence; clear overrides everything.
    always_comb begin
        state_d    = state_q;
        load_resp  = 1'b0;
        resp_fail  = 1'b0;
        take_rdata = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_op == OP_NOP) begin
                        state_d   = RESP;
                        load_resp = 1'b1;
                    end else if (reject) begin
                        state_d   = RESP;
                        load_resp = 1'b1;
                        resp_fail = 1'b1;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (reg_gnt_i) begin
                    if (we_q) begin
                        state_d   = RESP;
                        load_resp = 1'b1;
                    end else begin
                        state_d = RDATA;
                    end
                end else if (timeout) begin
                    state_d   = RESP;
                    load_resp = 1'b1;
                    resp_fail = 1'b1;
                end
            end
            RDATA: begin
                if (reg_rvalid_i) begin
                    state_d    = RESP;
                    load_resp  = 1'b1;
                    take_rdata = 1'b1;
                end else if (timeout) begin
                    state_d   = RESP;
                    load_resp = 1'b1;
                    resp_fail = 1'b1;
                end
            end
            RESP: begin
                if (dmi_resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (dmi_clear_i) begin
            state_d    = IDLE;
            load_resp  = 1'b0;
            resp_fail  = 1'b0;
            take_rdata = 1'b0;
        end
    end

    always_comb begin
        dmi_req_ready_o  = (state_q == IDLE) && !dmi_clear_i;
        dmi_resp_valid_o = (state_q == RESP);
        reg_req_o        = (state_q == ACCESS);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            resp_data_q <= '0;
            resp_code_q <= RSP_SUCCESS;
            cnt_q       <= '0;
        end else begin
            if (state_q == IDLE && state_d == ACCESS) begin
                addr_q  <= req_addr;
                we_q    <= (req_op == OP_WRITE);
                wdata_q <= req_data;
            end
            if (load_resp) begin
                resp_data_q <= take_rdata ? reg_rdata_i : '0;
                resp_code_q <= resp_fail ? RSP_FAILED : RSP_SUCCESS;
            end else if (dmi_clear_i) begin
                resp_data_q <= '0;
                resp_code_q <= RSP_SUCCESS;
            end
            if (dmi_clear_i || state_d != state_q) begin
                cnt_q <= '0;
            end else if (state_q == ACCESS || state_q == RDATA) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    assign dmi_resp_o  = {resp_data_q, resp_code_q};
    assign reg_we_o    = we_q;
    assign reg_addr_o  = addr_q;
    assign reg_wdata_o = wdata_q;

endmodule

// File: tb/tb_dmi_responder.sv
// Self-checking bench for dmi_responder: vector table plus scoreboarded response checks.
`timescale 1ns/1ps
module tb_dmi_responder;

    localparam logic [1:0] OP_NOP = 2'd0, OP_RD = 2'd1, OP_WR = 2'd2, OP_RSV = 2'd3;
    localparam int NV = 11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic [40:0] dmi_req = '0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [33:0] resp;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic        reg_req;
    logic        reg_we;
    logic [6:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = '0;

    dmi_responder #(.MAX_ADDR(7'h40), .TIMEOUT_CYCLES(16)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .dmi_clear_i      (clear),
        .dmi_req_i        (dmi_req),
        .dmi_req_valid_i  (req_valid),
        .dmi_req_ready_o  (req_ready),
        .dmi_resp_o       (resp),
        .dmi_resp_valid_o (resp_valid),
        .dmi_resp_ready_i (resp_ready),
        .reg_req_o        (reg_req),
        .reg_we_o         (reg_we),
        .reg_addr_o       (reg_addr),
        .reg_wdata_o      (reg_wdata),
        .reg_gnt_i        (gnt),
        .reg_rvalid_i     (rvalid),
        .reg_rdata_i      (rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int resp_seen = 0;
    logic [33:0] exp_q[$];

    // Register-bus model configuration and observations
    int          gnt_at = 0;
    int          rv_delay = 0;
    logic [31:0] bus_rdata = '0;
    int          req_cycles = 0;
    int          rv_cd = 0;
    logic        seen_we = 1'b0;
    logic [6:0]  seen_addr = '0;
    logic [31:0] seen_wdata = '0;

    typedef struct {
        logic [6:0]  addr;
        logic [1:0]  op;
        logic [31:0] data;
        int          gnt_at;
        int          rv_delay;
        logic [31:0] rdata;
        logic [31:0] exp_data;
        logic [1:0]  exp_code;
        int          exp_cycles;
    } vec_t;

    vec_t vecs[NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: compare each consumed response with the oldest expectation
    initial begin
        logic [33:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_resp: got %0h expected no response", resp);
                end else begin
                    e = exp_q.pop_front();
                    check("resp", 64'(resp), 64'(e));
                end
                resp_seen++;
            end
        end
    end

    // gnt after gnt_at request cycles (0 = never); rvalid rv_delay cycles after a read grant (0 = never)
    initial begin
        forever begin
            @(negedge clk);
            rvalid = 1'b0;
            rdata  = 32'hA5A5_A5A5;
            if (rv_cd > 0) begin
                rv_cd--;
                if (rv_cd == 0) begin
                    rvalid = 1'b1;
                    rdata  = bus_rdata;
                end
            end
            if (gnt && !reg_we && rv_delay > 0) begin
                rv_cd = rv_delay - 1;
                if (rv_cd == 0) begin
                    rvalid = 1'b1;
                    rdata  = bus_rdata;
                end
            end
            gnt = 1'b0;
            if (reg_req) begin
                req_cycles++;
                seen_we    = reg_we;
                seen_addr  = reg_addr;
                seen_wdata = reg_wdata;
                if (req_cycles == gnt_at) gnt = 1'b1;
            end
        end
    end

    task automatic arm(input int g, input int r, input logic [31:0] d);
        gnt_at     = g;
        rv_delay   = r;
        bus_rdata  = d;
        req_cycles = 0;
        rv_cd      = 0;
        seen_we    = 1'b0;
        seen_addr  = '0;
        seen_wdata = '0;
    endtask

    task automatic send(input logic [6:0] a, input logic [1:0] op, input logic [31:0] d);
        int n = 0;
        @(negedge clk);
        dmi_req   = {a, op, d};
        req_valid = 1'b1;
        #1;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!req_ready) begin
            checks++;
            failures++;
            $display("FAIL req_accept: ready=%0b after %0d cycles, required 1", req_ready, n);
        end
        @(negedge clk);
        req_valid = 1'b0;
        dmi_req   = '0;
    endtask

    task automatic wait_resp(input int target, input string name);
        int n = 0;
        while (resp_seen < target && n < 200) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (resp_seen < target) begin
            checks++;
            failures++;
            $display("FAIL %s: no response after %0d cycles, required one", name, n);
        end
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic expect_access(input string name, input logic [6:0] a, input logic [1:0] op,
                                 input logic [31:0] d, input logic [31:0] e_data, input logic [1:0] e_code,
                                 input int e_cycles);
        int target = resp_seen + 1;
        exp_q.push_back({e_data, e_code});
        send(a, op, d);
        wait_resp(target, name);
        check({name, "_req_cycles"}, 64'(req_cycles), 64'(e_cycles));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int target;
        int n;
        logic [33:0] held;

        vecs[0]  = '{addr:7'h10, op:OP_WR,  data:32'hDEADBEEF, gnt_at:2,  rv_delay:0,  rdata:32'h0,
                     exp_data:32'h0,        exp_code:2'd0, exp_cycles:2};
        vecs[1]  = '{addr:7'h11, op:OP_RD,  data:32'h0,        gnt_at:4,  rv_delay:2,  rdata:32'h12345678,
                     exp_data:32'h12345678, exp_code:2'd0, exp_cycles:4};
        vecs[2]  = '{addr:7'h41, op:OP_RD,  data:32'h0,        gnt_at:1,  rv_delay:1,  rdata:32'h1,
                     exp_data:32'h0,        exp_code:2'd2, exp_cycles:0};
        vecs[3]  = '{addr:7'h05, op:OP_NOP, data:32'h0,        gnt_at:1,  rv_delay:1,  rdata:32'h1,
                     exp_data:32'h0,        exp_code:2'd0, exp_cycles:0};
        vecs[4]  = '{addr:7'h20, op:OP_WR,  data:32'h0000_0055, gnt_at:0, rv_delay:0,  rdata:32'h0,
                     exp_data:32'h0,        exp_code:2'd2, exp_cycles:16};
        vecs[5]  = '{addr:7'h40, op:OP_RD,  data:32'h0,        gnt_at:1,  rv_delay:1,  rdata:32'hCAFEF00D,
                     exp_data:32'hCAFEF00D, exp_code:2'd0, exp_cycles:1};
        vecs[6]  = '{addr:7'h3F, op:OP_WR,  data:32'h0F0F_1234, gnt_at:16, rv_delay:0, rdata:32'h0,
                     exp_data:32'h0,        exp_code:2'd0, exp_cycles:16};
        vecs[7]  = '{addr:7'h00, op:OP_RD,  data:32'h0,        gnt_at:2,  rv_delay:0,  rdata:32'h0,
                     exp_data:32'h0,        exp_code:2'd2, exp_cycles:2};
        vecs[8]  = '{addr:7'h10, op:OP_RSV, data:32'h0,        gnt_at:1,  rv_delay:1,  rdata:32'h1,
                     exp_data:32'h0,        exp_code:2'd2, exp_cycles:0};
        vecs[9]  = '{addr:7'h7F, op:OP_WR,  data:32'h1,        gnt_at:1,  rv_delay:0,  rdata:32'h0,
                     exp_data:32'h0,        exp_code:2'd2, exp_cycles:0};
        vecs[10] = '{addr:7'h12, op:OP_RD,  data:32'h0,        gnt_at:1,  rv_delay:16, rdata:32'h9876_5432,
                     exp_data:32'h98765432, exp_code:2'd0, exp_cycles:1};

        repeat (2) @(negedge clk);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'(1));
        check("rst_resp_valid", 64'(resp_valid), 64'(0));
        check("rst_resp", 64'(resp), 64'(0));
        check("rst_reg_req", 64'(reg_req), 64'(0));
        check("rst_reg_we", 64'(reg_we), 64'(0));
        check("rst_reg_addr", 64'(reg_addr), 64'(0));
        check("rst_reg_wdata", 64'(reg_wdata), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
`ifdef DMI_RESP_STICKY_ERR_EN
            pulse_clear();
`endif
            arm(vecs[i].gnt_at, vecs[i].rv_delay, vecs[i].rdata);
            target = resp_seen + 1;
            exp_q.push_back({vecs[i].exp_data, vecs[i].exp_code});
            send(vecs[i].addr, vecs[i].op, vecs[i].data);
            wait_resp(target, $sformatf("vec%0d_resp", i));
            check($sformatf("vec%0d_req_cycles", i), 64'(req_cycles), 64'(vecs[i].exp_cycles));
            if (vecs[i].exp_cycles > 0) begin
                check($sformatf("vec%0d_addr", i), 64'(seen_addr), 64'(vecs[i].addr));
                check($sformatf("vec%0d_we", i), 64'(seen_we), 64'(vecs[i].op == OP_WR));
                if (vecs[i].op == OP_WR)
                    check($sformatf("vec%0d_wdata", i), 64'(seen_wdata), 64'(vecs[i].data));
            end
            repeat (2) @(negedge clk);
        end

        // Backpressure: response held stable, no new request accepted, then cleared away
        arm(1, 1, 32'h0BADF00D);
        resp_ready = 1'b0;
        exp_q.push_back({32'h0BADF00D, 2'd0});
        send(7'h15, OP_RD, 32'h0);
        n = 0;
        #1;
        while (!resp_valid && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        held = {32'h0BADF00D, 2'd0};
        for (int c = 0; c < 10; c++) begin
            check("bp_valid", 64'(resp_valid), 64'(1));
            check("bp_resp", 64'(resp), 64'(held));
            check("bp_req_ready", 64'(req_ready), 64'(0));
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        clear = 1'b1;
        #1;
        check("clr_ready_low", 64'(req_ready), 64'(0));
        @(negedge clk);
        clear = 1'b0;
        #1;
        check("clr_valid_dropped", 64'(resp_valid), 64'(0));
        check("clr_ready_back", 64'(req_ready), 64'(1));
        void'(exp_q.pop_front());
        resp_ready = 1'b1;

        // Clear while waiting for read data; the late rvalid must produce nothing
        arm(1, 6, 32'h11111111);
        send(7'h22, OP_RD, 32'h0);
        repeat (2) @(negedge clk);
        pulse_clear();
        #1;
        check("clr_rdata_reg_req", 64'(reg_req), 64'(0));
        check("clr_rdata_valid", 64'(resp_valid), 64'(0));
        repeat (8) @(negedge clk);
        #1;
        check("late_rvalid_ignored", 64'(resp_valid), 64'(0));
        arm(1, 0, 32'h0);
        expect_access("post_clear_wr", 7'h30, OP_WR, 32'h7777_0001, 32'h0, 2'd0, 1);

        // Asynchronous reset in the middle of an access
        repeat (2) @(negedge clk);
        arm(0, 0, 32'h0);
        send(7'h10, OP_WR, 32'hFFFF_0000);
        repeat (2) @(negedge clk);
        #1;
        check("pre_rst_reg_req", 64'(reg_req), 64'(1));
        rst_n = 1'b0;
        #1;
        check("mid_rst_reg_req", 64'(reg_req), 64'(0));
        check("mid_rst_req_ready", 64'(req_ready), 64'(1));
        check("mid_rst_reg_addr", 64'(reg_addr), 64'(0));
        check("mid_rst_reg_wdata", 64'(reg_wdata), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        arm(1, 0, 32'h0);
        expect_access("post_rst_nop", 7'h01, OP_NOP, 32'h0, 32'h0, 2'd0, 0);

`ifdef DMI_RESP_STICKY_ERR_EN
        pulse_clear();
        arm(0, 0, 32'h0);
        expect_access("sticky_timeout", 7'h10, OP_WR, 32'hDEADBEEF, 32'h0, 2'd2, 16);
        arm(1, 0, 32'h0);
        expect_access("sticky_wr_blocked", 7'h10, OP_WR, 32'hDEADBEEF, 32'h0, 2'd2, 0);
        arm(1, 0, 32'h0);
        expect_access("sticky_nop", 7'h10, OP_NOP, 32'h0, 32'h0, 2'd0, 0);
        pulse_clear();
        arm(1, 0, 32'h0);
        expect_access("sticky_cleared_wr", 7'h10, OP_WR, 32'hDEADBEEF, 32'h0, 2'd0, 1);
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
